// File: rtl/trace_retire_queue_if.sv
// rtl/trace_retire_queue_if.sv - retirement input bus and trace record output bus
interface trace_retire_queue_if;
  logic        ret_valid;
  logic [31:0] ret_insn;
  logic [31:0] ret_pc;
  logic [31:0] ret_pc_next;
  logic [4:0]  ret_rd_addr;
  logic [31:0] ret_rd_wdata;
  logic        ret_trap;
  logic        ret_halt;
  logic        core_stall;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_order;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic        out_trap;
  logic        out_halt;

  modport master (
    output ret_valid, ret_insn, ret_pc, ret_pc_next, ret_rd_addr, ret_rd_wdata,
           ret_trap, ret_halt, out_ready,
    input  core_stall, out_valid, out_order, out_insn, out_pc, out_pc_next,
           out_rd_addr, out_rd_wdata, out_trap, out_halt
  );

  modport slave (
    input  ret_valid, ret_insn, ret_pc, ret_pc_next, ret_rd_addr, ret_rd_wdata,
           ret_trap, ret_halt, out_ready,
    output core_stall, out_valid, out_order, out_insn, out_pc, out_pc_next,
           out_rd_addr, out_rd_wdata, out_trap, out_halt
  );
endinterface

// File: rtl/trace_retire_queue.sv
// rtl/trace_retire_queue.sv - first-word-fall-through queue of retired-instruction trace records
module trace_retire_queue #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trc_en,
  trace_retire_queue_if.slave  bus,
  output logic                 overflow,
  output logic                 done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
  } rec_t;

  state_t      state;
  logic [AW:0] count;
  logic [AW:0] count_nxt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [63:0] order;
  rec_t        mem [DEPTH];
  rec_t        head_rec;
  rec_t        new_rec;

  logic push;
  logic pop;
  logic drop;
  logic flush;

  // Leaving a session mid-flight takes priority over any push/pop that edge.
  assign flush = ((state == RUN) || (state == DRAIN)) && !trc_en;
  assign pop   = (count != '0) && bus.out_ready;
  assign push  = (state == RUN) && trc_en && bus.ret_valid && ((count != FULL) || pop);
  assign drop  = (state == RUN) && trc_en && bus.ret_valid && (count == FULL) && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + ONE;
    else if (pop && !push)
      count_nxt = count - ONE;
  end

  always_comb begin
    new_rec          = '0;
    new_rec.order    = order;
    new_rec.insn     = bus.ret_insn;
    new_rec.pc       = bus.ret_pc;
    new_rec.pc_next  = bus.ret_pc_next;
    new_rec.rd_addr  = bus.ret_rd_addr;
    new_rec.rd_wdata = (bus.ret_rd_addr == 5'd0) ? 32'd0 : bus.ret_rd_wdata;
    new_rec.trap     = bus.ret_trap;
    new_rec.halt     = bus.ret_halt;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= new_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      order    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count_nxt;
      if (push) order <= order + 64'd1;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (trc_en) begin
            state    <= RUN;
            order    <= '0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (push && bus.ret_halt) state <= DRAIN;
        end
        DRAIN: begin
          if (count_nxt == '0) state <= DONE;
        end
        DONE: begin
          if (!trc_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head_rec         = mem[head];
  assign bus.core_stall   = (state == RUN) && (count == FULL);
  assign bus.out_valid    = (count != '0);
  assign bus.out_order    = bus.out_valid ? head_rec.order : 64'd0;
  assign bus.out_insn     = head_rec.insn;
  assign bus.out_pc       = head_rec.pc;
  assign bus.out_pc_next  = head_rec.pc_next;
  assign bus.out_rd_addr  = head_rec.rd_addr;
  assign bus.out_rd_wdata = head_rec.rd_wdata;
  assign bus.out_trap     = head_rec.trap;
  assign bus.out_halt     = head_rec.halt;
  assign done             = (state == DONE);

endmodule

// File: tb/tb_trace_retire_queue.sv
// tb/tb_trace_retire_queue.sv - directed self-checking bench for trace_retire_queue
module tb_trace_retire_queue;

  logic clk;
  logic rst_n;
  logic trc_en;
  logic overflow;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;

  trace_retire_queue_if bus ();

  trace_retire_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trc_en   (trc_en),
    .bus      (bus.slave),
    .overflow (overflow),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] wdata, input logic halt);
    bus.ret_valid    = 1'b1;
    bus.ret_insn     = 32'h0000_0013 ^ pc;
    bus.ret_pc       = pc;
    bus.ret_pc_next  = pc + 32'd4;
    bus.ret_rd_addr  = rd;
    bus.ret_rd_wdata = wdata;
    bus.ret_trap     = 1'b0;
    bus.ret_halt     = halt;
  endtask

  task automatic idle();
    bus.ret_valid = 1'b0;
    bus.ret_halt  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b1;
    trc_en = 1'b0;
    bus.out_ready = 1'b0;
    retire(32'h0, 5'd1, 32'h0, 1'b0);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_core_stall", 64'(bus.core_stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_order", bus.out_order, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // three retires, sink always ready
    trc_en = 1'b1;
    bus.out_ready = 1'b1;
    step();
    retire(32'h0, 5'd1, 32'h11, 1'b0);
    step();
    check("seq0_valid", 64'(bus.out_valid), 64'd1);
    check("seq0_order", bus.out_order, 64'd0);
    check("seq0_pc", 64'(bus.out_pc), 64'h0);
    retire(32'h4, 5'd2, 32'h22, 1'b0);
    step();
    check("seq1_order", bus.out_order, 64'd1);
    check("seq1_pc", 64'(bus.out_pc), 64'h4);
    check("seq1_insn", 64'(bus.out_insn), 64'h17);
    retire(32'h8, 5'd3, 32'h33, 1'b0);
    step();
    check("seq2_order", bus.out_order, 64'd2);
    check("seq2_pc", 64'(bus.out_pc), 64'h8);
    check("seq2_pc_next", 64'(bus.out_pc_next), 64'hC);
    check("seq2_wdata", 64'(bus.out_rd_wdata), 64'h33);
    idle();
    step();
    check("seq_empty", 64'(bus.out_valid), 64'd0);

    // x0 destination writes are scrubbed; head holds while not ready
    bus.out_ready = 1'b0;
    retire(32'h20, 5'd0, 32'hDEAD_BEEF, 1'b0);
    step();
    check("x0_wdata", 64'(bus.out_rd_wdata), 64'h0);
    check("x0_order", bus.out_order, 64'd3);
    retire(32'h24, 5'd5, 32'h1234_5678, 1'b0);
    step();
    check("hold_order", bus.out_order, 64'd3);
    check("hold_pc", 64'(bus.out_pc), 64'h20);
    idle();
    bus.out_ready = 1'b1;
    step();
    check("after_pop_order", bus.out_order, 64'd4);
    check("after_pop_rd", 64'(bus.out_rd_addr), 64'd5);
    check("after_pop_wdata", 64'(bus.out_rd_wdata), 64'h1234_5678);
    step();
    check("after_pop_empty", 64'(bus.out_valid), 64'd0);

    // overflow: 5 retires into a 4-deep queue with a stalled sink
    trc_en = 1'b0;
    step();
    trc_en = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire(32'h100 + 32'(4 * i), 5'd1, 32'(i), 1'b0);
      step();
      if (i == 2) check("ovf_stall_at3", 64'(bus.core_stall), 64'd0);
      if (i == 3) begin
        check("ovf_stall_at4", 64'(bus.core_stall), 64'd1);
        check("ovf_not_yet", 64'(overflow), 64'd0);
      end
    end
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head_order", bus.out_order, 64'd0);
    check("ovf_head_pc", 64'(bus.out_pc), 64'h100);
    idle();
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    check("ovf_last_order", bus.out_order, 64'd3);
    check("ovf_last_pc", 64'(bus.out_pc), 64'h10C);
    step();
    check("ovf_drained", 64'(bus.out_valid), 64'd0);
    retire(32'h120, 5'd1, 32'h0, 1'b0);
    step();
    check("ovf_next_order", bus.out_order, 64'd4);
    idle();
    step();

    // full queue with simultaneous push and pop
    trc_en = 1'b0;
    step();
    trc_en = 1'b1;
    step();
    check("sess_ovf_clear", 64'(overflow), 64'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(32'h200 + 32'(4 * i), 5'd1, 32'(i), 1'b0);
      step();
    end
    check("full_stall", 64'(bus.core_stall), 64'd1);
    retire(32'h210, 5'd1, 32'h0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check("pp_overflow", 64'(overflow), 64'd0);
    check("pp_still_full", 64'(bus.core_stall), 64'd1);
    check("pp_head_order", bus.out_order, 64'd1);
    idle();
    step();
    check("pp_order2", bus.out_order, 64'd2);
    step();
    check("pp_order3", bus.out_order, 64'd3);
    step();
    check("pp_order4", bus.out_order, 64'd4);
    check("pp_order4_pc", 64'(bus.out_pc), 64'h210);
    step();
    check("pp_empty", 64'(bus.out_valid), 64'd0);

    // halt with two records queued, then drain to DONE
    bus.out_ready = 1'b0;
    retire(32'h400, 5'd1, 32'h0, 1'b0);
    step();
    retire(32'h404, 5'd1, 32'h0, 1'b0);
    step();
    retire(32'h408, 5'd1, 32'h0, 1'b1);
    step();
    check("halt_head_order", bus.out_order, 64'd5);
    check("drain_no_stall", 64'(bus.core_stall), 64'd0);
    retire(32'h40C, 5'd1, 32'h0, 1'b0);
    step();
    check("drain_ignore_ovf", 64'(overflow), 64'd0);
    bus.out_ready = 1'b1;
    step();
    check("drain_order6", bus.out_order, 64'd6);
    check("drain_done0", 64'(done), 64'd0);
    step();
    check("drain_order7", bus.out_order, 64'd7);
    check("drain_halt", 64'(bus.out_halt), 64'd1);
    check("drain_done1", 64'(done), 64'd0);
    step();
    check("done_empty", 64'(bus.out_valid), 64'd0);
    check("done_set", 64'(done), 64'd1);
    step();
    check("done_ignore_push", 64'(bus.out_valid), 64'd0);
    check("done_held", 64'(done), 64'd1);
    trc_en = 1'b0;
    idle();
    step();
    check("done_cleared", 64'(done), 64'd0);

    // asynchronous reset mid-session discards queued records
    trc_en = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retire(32'h500 + 32'(4 * i), 5'd1, 32'h0, 1'b0);
      step();
    end
    check("prerst_valid", 64'(bus.out_valid), 64'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_order", bus.out_order, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_release_valid", 64'(bus.out_valid), 64'd0);
    retire(32'h600, 5'd1, 32'h0, 1'b0);
    step();
    check("arst_new_order", bus.out_order, 64'd0);
    check("arst_new_pc", 64'(bus.out_pc), 64'h600);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_retire_queue.md
TRACE_RETIRE_QUEUE -- requirements
Module: trace_retire_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered retirement records (power of 2, >=2).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 trc_en  in  1  trace session enable.
REQ-005 ret_valid  in  1  core retires one instruction this cycle.
REQ-006 ret_insn / ret_pc / ret_pc_next  in  32 each  retired instruction word, its PC, next PC.
REQ-007 ret_rd_addr  in  5; ret_rd_wdata  in  32  destination register and written value.
REQ-008 ret_trap / ret_halt  in  1 each  retirement trapped / is final instruction.
REQ-009 core_stall  out  1  core must hold retirement this cycle.
REQ-010 out_valid  out  1; out_ready  in  1  sink handshake.
REQ-011 out_order  out  64  retirement sequence number.
REQ-012 out_insn / out_pc / out_pc_next  out  32 each; out_rd_addr  out  5; out_rd_wdata  out  32; out_trap / out_halt  out  1 each  head record fields.
REQ-013 overflow  out  1  sticky: a retirement was dropped.
REQ-014 done  out  1  session finished and queue drained.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE->RUN when trc_en=1; on this transition order counter and overflow clear to 0.
REQ-017 RUN->DRAIN on the edge a record with ret_halt=1 is accepted.
REQ-018 DRAIN->DONE when queue count reaches 0 (after last pop).
REQ-019 DONE->IDLE when trc_en=0; from RUN or DRAIN, trc_en=0 -> IDLE with queue flushed (count=0) in the same edge.
REQ-020 Push: in RUN only, ret_valid=1 and (count<DEPTH or pop same cycle) -> record written at tail, tagged with current order, order+1.
REQ-021 Stored rd_wdata forced to 0 when ret_rd_addr=0.
REQ-022 ret_valid in IDLE, DRAIN, DONE ignored; no order increment, no overflow.
REQ-023 ret_valid in RUN with count=DEPTH and no pop -> record dropped, overflow set to 1, order not incremented.
REQ-024 core_stall = 1 exactly when state=RUN and count=DEPTH (combinational).
REQ-025 First-word-fall-through: out_valid = (count!=0); out_* reflect head entry; record pushed at edge N visible on out_* in the cycle after edge N.
REQ-026 Pop when out_valid && out_ready; head advances, count-1.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance; allowed at count=0 only as push (pop has no effect when out_valid=0).
REQ-028 While out_valid=1 and out_ready=0, all out_* held stable.
REQ-029 Pointers wrap modulo DEPTH; count range 0..DEPTH; order 64-bit, wraps at 2^64.
REQ-030 done = 1 exactly in DONE.

Reset
REQ-031 rst_n=0 asynchronously forces: state IDLE, count 0, pointers 0, order 0, overflow 0.
REQ-032 During reset and after release: out_valid=0, core_stall=0, done=0, out_order=0; other out_* are don't-care while out_valid=0.
REQ-033 Reset asserted mid-session discards all buffered records; no record emerges after release until a new RUN push.

Verification
REQ-034 trc_en=1, 3 retires pc=0x0,0x4,0x8, out_ready=1 -> out records order 0,1,2 with matching pc, each visible one cycle after push.
REQ-035 DEPTH=4, out_ready=0, 5 consecutive retires -> core_stall=1 after 4th, 5th dropped, overflow=1, out_order of head=0, count=4.
REQ-036 Full queue, ret_valid=1 and out_ready=1 same cycle -> no drop, overflow stays 0, count stays 4, new record order=4.
REQ-037 Retire with rd_addr=0, rd_wdata=0xDEADBEEF -> out_rd_wdata=0x00000000.
REQ-038 Retire with ret_halt=1 while 2 records queued -> DRAIN, further ret_valid ignored, done=1 after 3rd pop; trc_en=0 -> IDLE, done=0.
REQ-039 rst_n pulsed low with 3 records queued -> out_valid=0 immediately; after release and new session, first out_order=0.
